// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PARITY_EVEN      = 1'b0;
    localparam logic PARITY_ODD       = 1'b1;
    localparam int   DEFAULT_PRESCALE = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line, frame configuration and parallel result of the UART receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      parity_enable;
    logic                      parity_type;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      data_valid;
    logic                      parity_error;
    logic                      stop_error;

    modport master (
        output RX_IN, prescale, parity_enable, parity_type,
        input  P_DATA, data_valid, parity_error, stop_error
    );

    modport slave (
        input  RX_IN, prescale, parity_enable, parity_type,
        output P_DATA, data_valid, parity_error, stop_error
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and bit decision for uart_rx.
// UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around the bit centre instead of a single sample.
module uart_rx_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    input  logic                      active,
    input  logic                      start,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      sample_bit,
    output logic                      sample_strobe,
    output logic                      bit_end
);
    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] half;

    assign half    = prescale >> 1;
    assign bit_end = active && (edge_cnt == prescale - ONE);

    // The detection cycle itself counts as edge 0, so the counter resumes at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (start) begin
            edge_cnt <= ONE;
        end else if (!active || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist;

    // Two-deep line history: at edge prescale/2 it holds the samples from the two preceding edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx};
        end
    end

    assign sample_strobe = active && (edge_cnt == half);
    assign sample_bit    = (hist[1] & hist[0]) | (hist[1] & rx) | (hist[0] & rx);
`else
    assign sample_strobe = active && (edge_cnt == half - ONE);
    assign sample_bit    = rx;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/parity/stop checking and deserialisation into a parallel word.
// Optional majority-vote sampling is enabled by defining UART_RX_MAJORITY_VOTE_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave bus
);
    localparam int                 CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]      LAST_BIT = CW'(DATA_WIDTH - 1);

    rx_state_e                 state;
    rx_state_e                 state_next;
    logic                      rx_hist;
    logic [PRESCALE_WIDTH-1:0] presc_lat;
    logic                      pen_lat;
    logic                      ptype_lat;
    logic [CW-1:0]             bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_err;
    logic                      exp_par;
    logic                      sample_bit;
    logic                      sample_strobe;
    logic                      bit_end;
    logic                      start_det;
    logic                      active;

    assign start_det = (state == IDLE) && rx_hist && !bus.RX_IN;
    assign active    = (state != IDLE);
    assign exp_par   = (ptype_lat == PARITY_EVEN) ? ^shift_reg : ~^shift_reg;

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) sampler (
        .clk          (CLK),
        .rst          (RST),
        .rx           (bus.RX_IN),
        .active       (active),
        .start        (start_det),
        .prescale     (presc_lat),
        .sample_bit   (sample_bit),
        .sample_strobe(sample_strobe),
        .bit_end      (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // STOP leaves at its sample point so a back-to-back start edge is not missed.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start_det) state_next = START;
            START: begin
                if (sample_strobe && sample_bit) state_next = IDLE;
                else if (bit_end)                state_next = DATA;
            end
            DATA:   if (bit_end && bit_cnt == LAST_BIT) state_next = pen_lat ? PARITY : STOP;
            PARITY: if (bit_end) state_next = STOP;
            STOP:   if (sample_strobe) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_hist          <= 1'b1;
            presc_lat        <= PRESCALE_WIDTH'(DEFAULT_PRESCALE);
            pen_lat          <= 1'b0;
            ptype_lat        <= PARITY_EVEN;
            bit_cnt          <= '0;
            shift_reg        <= '0;
            par_err          <= 1'b0;
            bus.P_DATA       <= '0;
            bus.data_valid   <= 1'b0;
            bus.parity_error <= 1'b0;
            bus.stop_error   <= 1'b0;
        end else begin
            rx_hist          <= bus.RX_IN;
            bus.data_valid   <= 1'b0;
            bus.parity_error <= 1'b0;
            bus.stop_error   <= 1'b0;
            if (start_det) begin
                presc_lat <= bus.prescale;
                pen_lat   <= bus.parity_enable;
                ptype_lat <= bus.parity_type;
                bit_cnt   <= '0;
                par_err   <= 1'b0;
            end
            if (state == DATA && sample_strobe) begin
                shift_reg[bit_cnt] <= sample_bit;
            end
            if (state == DATA && bit_end) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (state == PARITY && sample_strobe) begin
                par_err <= sample_bit ^ exp_par;
            end
            if (state == STOP && sample_strobe) begin
                bus.stop_error   <= !sample_bit;
                bus.parity_error <= pen_lat && par_err;
                if (sample_bit && !(pen_lat && par_err)) begin
                    bus.data_valid <= 1'b1;
                    bus.P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: serial frames in, strobes and word checked with timing.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_DELAY = 1;
`else
    localparam int VOTE_DELAY = 0;
`endif

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    uart_rx_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int   check_cnt  = 0;
    int   pass_cnt   = 0;
    int   tick_cnt   = 0;
    int   valid_cnt  = 0;
    int   perr_cnt   = 0;
    int   serr_cnt   = 0;
    int   long_cnt   = 0;
    int   strobe_at  = -1;
    int   frame_start = 0;
    logic prev_valid = 1'b0;
    logic prev_perr  = 1'b0;
    logic prev_serr  = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_cnt++;
        if (observed === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Each tick samples outputs on the falling edge before the caller drives new inputs.
    task automatic tick();
        @(negedge CLK);
        tick_cnt++;
        if (bus.data_valid)   valid_cnt++;
        if (bus.parity_error) perr_cnt++;
        if (bus.stop_error)   serr_cnt++;
        if ((bus.data_valid || bus.parity_error || bus.stop_error) && strobe_at < 0) strobe_at = tick_cnt;
        if ((bus.data_valid && prev_valid) || (bus.parity_error && prev_perr) ||
            (bus.stop_error && prev_serr)) long_cnt++;
        prev_valid = bus.data_valid;
        prev_perr  = bus.parity_error;
        prev_serr  = bus.stop_error;
    endtask

    task automatic idleTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clearCounts();
        valid_cnt = 0;
        perr_cnt  = 0;
        serr_cnt  = 0;
        strobe_at = -1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int presc, input logic pen,
                                 input logic ptype, input logic par_bit, input logic stop_bit,
                                 input int spike_bit, input bit toggle_ptype);
        logic [11:0] bits;
        int          nbits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (pen) begin
            bits[9] = par_bit;
            nbits   = 11;
        end else begin
            nbits   = 10;
        end
        bits[nbits-1]     = stop_bit;
        bus.prescale      = PW'(presc);
        bus.parity_enable = pen;
        bus.parity_type   = ptype;
        clearCounts();
        frame_start = tick_cnt;
        for (int b = 0; b < nbits; b++) begin
            for (int j = 0; j < presc; j++) begin
                bus.RX_IN = bits[b];
                if (b == spike_bit && j == presc / 2 - 1) bus.RX_IN = ~bits[b];
                if (toggle_ptype && b == 4 && j == 0) bus.parity_type = ~ptype;
                tick();
            end
        end
    endtask

    task automatic checkFrame(input string tag, input int exp_valid, input int exp_perr,
                              input int exp_serr, input logic [7:0] exp_data,
                              input int stop_idx, input int presc);
        checkOutput({tag, "_valid_cnt"}, valid_cnt, exp_valid);
        checkOutput({tag, "_perr_cnt"}, perr_cnt, exp_perr);
        checkOutput({tag, "_serr_cnt"}, serr_cnt, exp_serr);
        checkOutput({tag, "_p_data"}, bus.P_DATA, exp_data);
        checkOutput({tag, "_latency"}, strobe_at - frame_start, stop_idx * presc + presc / 2 + VOTE_DELAY);
    endtask

    initial begin
        RST               = 1'b1;
        bus.RX_IN         = 1'b1;
        bus.prescale      = PW'(DEFAULT_PRESCALE);
        bus.parity_enable = 1'b0;
        bus.parity_type   = PARITY_EVEN;
        idleTicks(3);
        checkOutput("rst_p_data", bus.P_DATA, 8'h00);
        checkOutput("rst_valid", bus.data_valid, 1'b0);
        checkOutput("rst_perr", bus.parity_error, 1'b0);
        checkOutput("rst_serr", bus.stop_error, 1'b0);
        RST = 1'b0;
        idleTicks(5);

        applyStimulus(8'hA5, 8, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1, 1'b0);
        checkFrame("a5", 1, 0, 0, 8'hA5, 9, 8);
        idleTicks(4);

        applyStimulus(8'h3C, 16, 1'b1, PARITY_EVEN, 1'b0, 1'b1, -1, 1'b0);
        checkFrame("3c_even", 1, 0, 0, 8'h3C, 10, 16);
        idleTicks(4);
        applyStimulus(8'h3C, 16, 1'b1, PARITY_EVEN, 1'b1, 1'b1, -1, 1'b0);
        checkFrame("3c_bad_par", 0, 1, 0, 8'h3C, 10, 16);
        idleTicks(4);

        applyStimulus(8'h55, 8, 1'b0, PARITY_EVEN, 1'b0, 1'b0, -1, 1'b0);
        checkFrame("55_bad_stop", 0, 0, 1, 8'h3C, 9, 8);
        bus.RX_IN = 1'b0;
        clearCounts();
        idleTicks(100);
        checkOutput("held_low_strobes", valid_cnt + perr_cnt + serr_cnt, 0);
        bus.RX_IN = 1'b1;
        idleTicks(4);

        clearCounts();
        bus.RX_IN = 1'b0;
        idleTicks(2);
        bus.RX_IN = 1'b1;
        idleTicks(10);
        checkOutput("glitch_strobes", valid_cnt + perr_cnt + serr_cnt, 0);
        applyStimulus(8'h81, 8, 1'b0, PARITY_EVEN, 1'b0, 1'b1, -1, 1'b0);
        checkFrame("81", 1, 0, 0, 8'h81, 9, 8);
        idleTicks(4);

        applyStimulus(8'h00, 32, 1'b1, PARITY_ODD, 1'b1, 1'b1, -1, 1'b1);
        checkFrame("b2b_00", 1, 0, 0, 8'h00, 10, 32);
        applyStimulus(8'hFF, 32, 1'b1, PARITY_ODD, 1'b1, 1'b1, -1, 1'b1);
        checkFrame("b2b_ff", 1, 0, 0, 8'hFF, 10, 32);
        idleTicks(4);

        // 0x5A LSB first: start, then data bits 0,1,0 before reset hits mid-DATA.
        bus.prescale      = PW'(8);
        bus.parity_enable = 1'b0;
        clearCounts();
        bus.RX_IN = 1'b0; idleTicks(8);
        bus.RX_IN = 1'b0; idleTicks(8);
        bus.RX_IN = 1'b1; idleTicks(8);
        bus.RX_IN = 1'b0; idleTicks(4);
        RST       = 1'b1;
        bus.RX_IN = 1'b1;
        tick();
        checkOutput("midrst_p_data", bus.P_DATA, 8'h00);
        checkOutput("midrst_valid", bus.data_valid, 1'b0);
        RST = 1'b0;
        idleTicks(100);
        checkOutput("midrst_strobes", valid_cnt + perr_cnt + serr_cnt, 0);
        checkOutput("midrst_p_data_hold", bus.P_DATA, 8'h00);

`ifdef UART_RX_MAJORITY_VOTE_EN
        applyStimulus(8'h5A, 8, 1'b0, PARITY_EVEN, 1'b0, 1'b1, 3, 1'b0);
        checkFrame("vote_5a", 1, 0, 0, 8'h5A, 9, 8);
        idleTicks(4);
`endif

        checkOutput("no_long_strobe", long_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
